// File: rtl/multdiv_issue_control_pkg.sv
// Shared constants and types for the multdiv issue controller.
package multdiv_issue_control_pkg;

    // Instruction field encodings
    localparam logic [4:0] OpcRtype = 5'b00000;
    localparam logic [4:0] AluMul   = 5'b00110;
    localparam logic [4:0] AluDiv   = 5'b00111;

    // Exception redirect target and codes
    localparam logic [4:0]  RegRstatus = 5'd30;
    localparam logic [31:0] ExcMul     = 32'd1;
    localparam logic [31:0] ExcDiv     = 32'd3;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } md_state_e;

endpackage

// File: rtl/multdiv_issue_control_if.sv
// Start/ready handshake between the issue controller and the multdiv unit.
interface multdiv_issue_control_if;

    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    // Controller side: issues starts and operands, receives completion
    modport master (
        output ctrl_MULT, ctrl_DIV, operandA, operandB,
        input  data_result, data_exception, data_resultRDY
    );

    // Unit side
    modport slave (
        input  ctrl_MULT, ctrl_DIV, operandA, operandB,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/multdiv_issue_control_md_decode.sv
// Combinational mul/div decode; also usable by hazard detection.
module multdiv_issue_control_md_decode
    import multdiv_issue_control_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic        is_mul_o,
    output logic        is_div_o,
    output logic [4:0]  rd_o
);

    logic is_rtype;
    logic unused_insn_bits;

    // Only opcode, ALU op and rd fields matter here
    always_comb begin
        is_rtype         = (insn_i[31:27] == OpcRtype);
        is_mul_o         = is_rtype && (insn_i[6:2] == AluMul);
        is_div_o         = is_rtype && (insn_i[6:2] == AluDiv);
        rd_o             = insn_i[26:22];
        unused_insn_bits = ^{insn_i[21:7], insn_i[1:0]};
    end

endmodule

// File: rtl/multdiv_issue_control.sv
// Issues mul/div to the multi-cycle unit, stalls the pipeline, produces one writeback beat.
module multdiv_issue_control
    import multdiv_issue_control_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             insn,
    input  logic                    flush,
    input  logic [31:0]             dataRegA,
    input  logic [31:0]             dataRegB,
    multdiv_issue_control_if.master md,
    output logic                    stall,
    output logic                    wb_valid,
    output logic [4:0]              wb_reg,
    output logic [31:0]             wb_data,
    output logic [CNT_W-1:0]        busy_cycles
);

    md_state_e        state_q, state_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             div_q, div_d;
    logic             exc_q, exc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_mul, is_div;
    logic [4:0] dec_rd;
    logic       start, timeout;

    multdiv_issue_control_md_decode u_decode (
        .insn_i   (insn),
        .is_mul_o (is_mul),
        .is_div_o (is_div),
        .rd_o     (dec_rd)
    );

    // Start is gated by reset so an asserted reset silences ctrl/stall immediately
    always_comb begin
        start   = !reset && (state_q == StIdle) && (is_mul || is_div) && !flush;
        timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush beats a same-cycle ready; ready beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (md.data_resultRDY || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand/result latches and saturating busy counter
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rd_d     = rd_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (start) begin
            op_a_d = dataRegA;
            op_b_d = dataRegB;
            rd_d   = dec_rd;
            div_d  = is_div;
            cnt_d  = '0;
        end else if (state_q == StBusy) begin
            if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
            if (!flush) begin
                if (md.data_resultRDY) begin
                    result_d = md.data_result;
                    exc_d    = md.data_exception;
                end else if (timeout) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            rd_q     <= '0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rd_q     <= rd_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // Outputs: start pulses, stall, and the single DONE writeback beat
    always_comb begin
        md.ctrl_MULT = start && is_mul;
        md.ctrl_DIV  = start && is_div;
        md.operandA  = op_a_q;
        md.operandB  = op_b_q;
        stall        = start || (state_q == StBusy);
        busy_cycles  = cnt_q;
        wb_valid     = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        if (state_q == StDone) begin
            if (exc_q) begin
                wb_valid = 1'b1;
                wb_reg   = RegRstatus;
                wb_data  = div_q ? ExcDiv : ExcMul;
            end else if (rd_q != 5'd0) begin
                wb_valid = 1'b1;
                wb_reg   = rd_q;
                wb_data  = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_control.sv
// Self-checking bench: the bench plays the multdiv unit and scoreboards writeback beats.
module tb_multdiv_issue_control;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = 7;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic             clock = 1'b0;
    logic             reset;
    logic [31:0]      insn, dataRegA, dataRegB;
    logic             flush;
    logic             stall, wb_valid;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] busy_cycles;

    multdiv_issue_control_if md_if ();

    multdiv_issue_control #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .insn        (insn),
        .flush       (flush),
        .dataRegA    (dataRegA),
        .dataRegB    (dataRegB),
        .md          (md_if),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy_cycles (busy_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every writeback beat must match the oldest expected beat
    always @(negedge clock) begin
        wb_exp_t e;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("wb_reg", 32'(wb_reg), 32'(e.rd));
                check_eq("wb_data", wb_data, e.data);
            end
        end
    end

    function automatic logic [31:0] mk_insn(input bit is_div, input logic [4:0] rd);
        logic [4:0] op;
        op = is_div ? 5'b00111 : 5'b00110;
        return {5'b00000, rd, 15'h2a5a, op, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // One md op from start through DONE; lat==0 means the unit never answers
    task automatic run_md(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit exc);
        logic [31:0] res;
        bit          exc_eff;
        int          nb;
        int          stalls;
        res     = is_div ? ((b == 0) ? 32'hffff_ffff : a / b) : a * b;
        exc_eff = exc || (lat == 0);
        nb      = (lat == 0) ? TIMEOUT : lat;
        insn     = mk_insn(is_div, rd);
        dataRegA = a;
        dataRegB = b;
        flush    = 1'b0;
        settle();
        check_eq("ctrl_mult_start", 32'(md_if.ctrl_MULT), 32'(!is_div));
        check_eq("ctrl_div_start", 32'(md_if.ctrl_DIV), 32'(is_div));
        stalls = int'(stall);
        if (exc_eff) sb.push_back('{rd: 5'd30, data: is_div ? 32'd3 : 32'd1});
        else if (rd != 5'd0) sb.push_back('{rd: rd, data: res});
        tick();
        dataRegA = ~a;
        dataRegB = ~b;
        for (int k = 1; k <= nb; k++) begin
            if (lat != 0 && k == lat) begin
                md_if.data_resultRDY = 1'b1;
                md_if.data_result    = res;
                md_if.data_exception = exc;
            end
            settle();
            stalls += int'(stall);
            check_eq("ctrl_busy", 32'({md_if.ctrl_MULT, md_if.ctrl_DIV}), 32'd0);
            if (k == 1) begin
                check_eq("operandA", md_if.operandA, a);
                check_eq("operandB", md_if.operandB, b);
                check_eq("wb_busy", 32'(wb_valid), 32'd0);
            end
            tick();
            md_if.data_resultRDY = 1'b0;
            md_if.data_result    = '0;
            md_if.data_exception = 1'b0;
        end
        settle();
        check_eq("stall_done", 32'(stall), 32'd0);
        check_eq("wb_valid_done", 32'(wb_valid), 32'(exc_eff || rd != 5'd0));
        check_eq("busy_cycles", 32'(busy_cycles), 32'(nb));
        check_eq("stall_total", stalls, nb + 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        insn                 = Nop;
        flush                = 1'b0;
        dataRegA             = '0;
        dataRegB             = '0;
        md_if.data_result    = '0;
        md_if.data_exception = 1'b0;
        md_if.data_resultRDY = 1'b0;
        repeat (2) tick();
        settle();
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_busy_cycles", 32'(busy_cycles), 32'd0);
        check_eq("rst_operandA", md_if.operandA, 32'd0);
        reset = 1'b0;
        tick();

        // md in DX but squashed: must not start
        insn  = mk_insn(1'b0, 5'd5);
        flush = 1'b1;
        settle();
        check_eq("flush_idle_ctrl", 32'(md_if.ctrl_MULT), 32'd0);
        check_eq("flush_idle_stall", 32'(stall), 32'd0);
        tick();
        insn  = Nop;
        flush = 1'b0;
        settle();
        check_eq("flush_idle_next", 32'(stall), 32'd0);
        tick();

        run_md(1'b0, 32'd6, 32'd7, 5'd5, 16, 1'b0);
        insn = Nop;
        tick();
        run_md(1'b1, 32'd9, 32'd0, 5'd7, 5, 1'b1);
        insn = Nop;
        tick();
        run_md(1'b0, 32'd3, 32'd5, 5'd0, 2, 1'b0);
        insn = Nop;
        tick();

        // Flush 4 cycles into BUSY, late ready must be ignored
        insn     = mk_insn(1'b0, 5'd8);
        dataRegA = 32'd4;
        dataRegB = 32'd4;
        settle();
        check_eq("fl_start", 32'(md_if.ctrl_MULT), 32'd1);
        tick();
        for (int k = 1; k <= 3; k++) tick();
        flush = 1'b1;
        settle();
        check_eq("fl_stall_flush", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        insn  = Nop;
        settle();
        check_eq("fl_stall_after", 32'(stall), 32'd0);
        tick();
        tick();
        md_if.data_resultRDY = 1'b1;
        md_if.data_result    = 32'd16;
        settle();
        check_eq("fl_late_rdy_stall", 32'(stall), 32'd0);
        tick();
        md_if.data_resultRDY = 1'b0;
        md_if.data_result    = '0;
        settle();
        check_eq("fl_no_wb", 32'(wb_valid), 32'd0);
        tick();

        run_md(1'b0, 32'd100, 32'd200, 5'd12, 0, 1'b0);
        insn = Nop;
        tick();

        // Back-to-back: second op must start at R+2
        run_md(1'b0, 32'd11, 32'd13, 5'd3, 1, 1'b0);
        run_md(1'b1, 32'd100, 32'd7, 5'd4, 6, 1'b0);
        insn = Nop;
        tick();

        // Asynchronous reset in the middle of BUSY
        insn     = mk_insn(1'b1, 5'd9);
        dataRegA = 32'd55;
        dataRegB = 32'd5;
        settle();
        tick();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_stall", 32'(stall), 32'd0);
        check_eq("mid_rst_ctrl", 32'({md_if.ctrl_MULT, md_if.ctrl_DIV}), 32'd0);
        check_eq("mid_rst_operandA", md_if.operandA, 32'd0);
        check_eq("mid_rst_busy_cycles", 32'(busy_cycles), 32'd0);
        check_eq("mid_rst_wb", 32'(wb_valid), 32'd0);
        insn = Nop;
        tick();
        reset = 1'b0;
        tick();
        settle();
        check_eq("post_rst_stall", 32'(stall), 32'd0);
        tick();
        tick();
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multdiv_issue_control.md
# multdiv_issue_control

Execute-stage controller that issues `mul`/`div` instructions to the multi-cycle multdiv unit and holds the pipeline until the result returns. It sits beside the execute ALU path and decodes the instruction in DX. It latches operands, pulses the unit's start controls and counts cycles. On completion it presents one writeback beat, redirected to `$rstatus` on exception. It is the initiator side of the multdiv start/ready handshake.

## Interface
Parameters:
- `TIMEOUT`, 64: BUSY cycles without `data_resultRDY` before a forced exception completion.
- `CNT_W`, 7: cycle-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `insn`  in  32  instruction currently in DX.
- `flush`  in  1  DX squash from branch/jump resolution.
- `dataRegA`, `dataRegB`  in  32  register operands for `insn`.
- `data_result`  in  32  multdiv result.
- `data_exception`  in  1  multdiv overflow / divide-by-zero, valid with ready.
- `data_resultRDY`  in  1  multdiv completion, single-cycle pulse.
- `ctrl_MULT`, `ctrl_DIV`  out  1  one-cycle start pulses (unit restarts on any pulse).
- `operandA`, `operandB`  out  32  latched operands, stable from start through completion.
- `stall`  out  1  freeze PC/FD/DX.
- `wb_valid`  out  1  writeback beat.
- `wb_reg`  out  5  writeback destination.
- `wb_data`  out  32  writeback value.
- `busy_cycles`  out  CNT_W  cycles spent in BUSY by the current or last op.

## Operation
- Decode: md = (insn[31:27]==00000) & (insn[6:2]==00110 for mul, 00111 for div); rd = insn[26:22].
- States: IDLE, BUSY, DONE.
- IDLE: if md & !flush, latch A, B, rd and op, pulse the matching ctrl, clear the counter, and go to BUSY. `stall` is asserted combinationally this cycle. `data_resultRDY` is ignored in IDLE.
- BUSY: `stall`=1 and the counter increments each cycle. On `data_resultRDY`, capture result and exception, then go to DONE. Otherwise, when the counter reaches TIMEOUT, go to DONE with exception forced to 1.
- BUSY with flush: abort to IDLE with no writeback. Flush takes priority over a same-cycle ready.
- DONE: `stall`=0 so the md instruction leaves DX at this edge. The block does not start a new op in DONE and returns to IDLE.
- Writeback in DONE:
  - Exception: `wb_reg`=30, `wb_data`=1 for mul, 3 for div.
  - No exception: `wb_reg`=rd, `wb_data`=result.
  - `wb_valid`=1 except when there is no exception and rd==0.
- `busy_cycles` saturates at TIMEOUT and holds its value until the next start.
- Reset, including mid-operation: state IDLE, all outputs 0, and latches cleared.

## Timing
- Start cycle S: ctrl pulse and `stall` are high during S. BUSY begins at S+1.
- If `data_resultRDY` arrives at cycle R (R ≥ S+1), DONE is cycle R+1. `wb_*` are valid only in R+1.
- Total stall is R−S+1 cycles. The minimum md latency is 3 cycles (S, R=S+1, DONE).
- `operandA/B` are registered at S. Those registered values drive the unit from S+1 onward.
- Back-to-back md: the next instruction is seen in IDLE at R+2 and starts there, with no bubble beyond DONE.
- Timeout: DONE at S+TIMEOUT+1.
- `wb_*` and ctrl outputs are 0 whenever they are not active.

## Structure
- Shared package holds:
  - opcode constants: R-type 00000, ALU mul 00110, div 00111.
  - `$rstatus` index 30.
  - exception codes: mul 1, div 3.
  - state enum.
- Natural sub-module: `md_decode` (insn → is_mul, is_div, rd). It is combinational and reusable by hazard logic.

## Test plan
- mul A=6, B=7, rd=5, ready 16 cycles after start → ctrl_MULT for exactly 1 cycle, stall for 17 cycles, then a single beat wb_reg=5, wb_data=42, busy_cycles=16.
- div A=9, B=0 with exception on ready → wb_reg=30, wb_data=3, wb_valid=1.
- mul targeting rd=0, no exception → wb_valid stays 0 and the stall sequence is unchanged.
- flush asserted 4 cycles into BUSY, ready arrives later → no wb beat, stall drops the cycle after flush, late ready ignored.
- No ready with TIMEOUT=64 → DONE at S+65, wb_reg=30, busy_cycles=64.
- Back-to-back mul then div; reset asserted mid-BUSY → second op starts the cycle after the first DONE; reset immediately forces stall=0, state IDLE, all outputs 0.
